// File: rtl/calc_pkg.sv
// Shared calculator key codes and keypad scanner state encoding.
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_CE   = 4'hC;
  localparam logic [3:0] KEY_CA   = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_EQ   = 4'hF;

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StEmit,
    StHold,
    StRelease
  } scan_state_e;

  // Returns {valid, index}; valid only when exactly one row is pulled low.
  function automatic logic [2:0] single_low_row(input logic [3:0] rs);
    logic [2:0] res;
    case (rs)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the key-event outputs toward the control unit.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] value;
  logic       trig;
  logic       clr_entry;
  logic       clr_all;

  modport master (input row, output col, value, trig, clr_entry, clr_all);
  modport slave  (output row, input col, value, trig, clr_entry, clr_all);
endinterface

// File: rtl/keypad_decode.sv
// Combinational (row index, column index) to key code lookup.
module keypad_decode
  import calc_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [1:0] col_idx_i,
  output logic [3:0] code_o
);

  always_comb begin
    code_o = 4'h0;
    unique case ({row_idx_i, col_idx_i})
      4'h0: code_o = 4'h1;
      4'h1: code_o = 4'h2;
      4'h2: code_o = 4'h3;
      4'h3: code_o = KEY_ADD;
      4'h4: code_o = 4'h4;
      4'h5: code_o = 4'h5;
      4'h6: code_o = 4'h6;
      4'h7: code_o = KEY_SUB;
      4'h8: code_o = 4'h7;
      4'h9: code_o = 4'h8;
      4'hA: code_o = 4'h9;
      4'hB: code_o = KEY_CE;
      4'hC: code_o = KEY_STAR;
      4'hD: code_o = 4'h0;
      4'hE: code_o = KEY_EQ;
      4'hF: code_o = KEY_CA;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one trig pulse per accepted key.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.master kp
);

  localparam int unsigned ScanW = $clog2(SCAN_CYCLES) + 1;
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [ScanW-1:0] ScanLast  = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DebW-1:0]  DebTarget = DebW'(DEBOUNCE_CYCLES);

  scan_state_e      state_q, state_d;
  logic [3:0]       rs_meta_q, rs_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d, deb_inc;
  logic [1:0]       key_row_q, key_row_d;
  logic [3:0]       key_pat_q, key_pat_d;
  logic [3:0]       value_q, value_d;
  logic [3:0]       key_code;
  logic [2:0]       row_hit;

  keypad_decode u_decode (
    .row_idx_i (key_row_q),
    .col_idx_i (col_idx_q),
    .code_o    (key_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta_q  <= 4'b1111;
      rs_q       <= 4'b1111;
      state_q    <= StScan;
      col_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      key_row_q  <= 2'd0;
      key_pat_q  <= 4'b1111;
      value_q    <= 4'h0;
    end else begin
      rs_meta_q  <= kp.row;
      rs_q       <= rs_meta_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      key_row_q  <= key_row_d;
      key_pat_q  <= key_pat_d;
      value_q    <= value_d;
    end
  end

  assign row_hit = single_low_row(rs_q);
  assign deb_inc = (deb_cnt_q >= DebTarget) ? deb_cnt_q : deb_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    key_row_d  = key_row_q;
    key_pat_d  = key_pat_q;
    value_d    = value_q;
    unique case (state_q)
      StScan: begin
        if (row_hit[2]) begin
          // Freeze the column on the key; the scan count restarts when scanning resumes.
          key_row_d  = row_hit[1:0];
          key_pat_d  = rs_q;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          state_d    = StDebounce;
        end else if (scan_cnt_q >= ScanLast) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      StDebounce: begin
        if (rs_q != key_pat_q) begin
          state_d    = StScan;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DebTarget) begin
            state_d = StEmit;
            value_d = key_code;
          end
        end
      end
      StEmit: state_d = StHold;
      StHold: begin
        if (rs_q == 4'b1111) begin
          deb_cnt_d = '0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (rs_q != 4'b1111) begin
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DebTarget) begin
            state_d    = StScan;
            col_idx_d  = col_idx_q + 2'd1;
            scan_cnt_d = '0;
          end
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_comb begin
    kp.col       = ~(4'b0001 << col_idx_q);
    kp.value     = value_q;
    kp.trig      = (state_q == StEmit);
    kp.clr_entry = ~((state_q == StEmit) && (value_q == KEY_CE));
    kp.clr_all   = ~((state_q == StEmit) && (value_q == KEY_CA));
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 1024: clock cycles each column is driven while scanning.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized samples needed for a press or a release (5 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port row, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col, output, 4: keypad column drive, one-hot active-low.
REQ-007 SHALL have port value, output, 4: code of the last accepted key, feeding the control unit's value input.
REQ-008 SHALL have port trig, output, 1: one-cycle high pulse per accepted key, feeding the control unit's trig input.
REQ-009 SHALL have port clr_entry, output, 1: active-low one-cycle pulse coincident with trig when key code 4'hC is accepted.
REQ-010 SHALL have port clr_all, output, 1: active-low one-cycle pulse coincident with trig when key code 4'hD is accepted.

Function
REQ-011 SHALL pass row through a two-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 SHALL implement states SCAN, DEBOUNCE, EMIT, HOLD, RELEASE.
REQ-013 SCAN: drive col[i] low for SCAN_CYCLES cycles, then advance i to i+1, wrapping 3 to 0.
REQ-014 SCAN: when exactly one bit of rs is low, latch (i, rs), keep col frozen, clear the counter, and go to DEBOUNCE.
REQ-015 SCAN: treat zero or two or more low rs bits as no key and continue scanning.
REQ-016 DEBOUNCE: increment the counter each cycle rs equals the latched pattern; on any mismatch return to SCAN at the next column.
REQ-017 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES, go to EMIT.
REQ-018 EMIT lasts one cycle: trig=1, value updated to the code, clr strobes per REQ-009/010, then go to HOLD.
REQ-019 value SHALL change only in EMIT and SHALL hold stable at all other times.
REQ-020 Key map SHALL be (row, col):
- r0 = 1, 2, 3, A
- r1 = 4, 5, 6, B
- r2 = 7, 8, 9, C
- r3 = E(*), 0, F(#), D
REQ-021 Code semantics: A = add, B = subtract, F = equals, C = clear entry, D = clear all, E = reserved (passed through).
REQ-022 HOLD: keep the latched column driven and wait until rs == 4'b1111, then clear the counter and go to RELEASE.
REQ-023 RELEASE: count consecutive all-high rs samples and reset the count on any low bit; at DEBOUNCE_CYCLES, return to SCAN at the next column.
REQ-024 A second key pressed while in HOLD or RELEASE SHALL produce no trig; auto-repeat is not supported.
REQ-025 trig SHALL never be high in two consecutive cycles, and never more than once per physical press.
REQ-026 Counters SHALL be sized as clog2 of the parameter plus 1, SHALL saturate rather than wrap, and SHALL support parameter value 1.

Reset
REQ-027 reset SHALL force: state SCAN, col=4'b1110, value=4'h0, trig=0, clr_entry=1, clr_all=1, synchronizer=4'b1111, counters=0.
REQ-028 Reset asserted mid-DEBOUNCE or mid-EMIT SHALL suppress any pending trig, and no trig SHALL follow reset release until a new full debounce completes.

Structure
REQ-029 A shared package calc_pkg SHALL hold the key code constants (KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_CE=4'hC, KEY_CA=4'hD, KEY_STAR=4'hE, KEY_EQ=4'hF) and the scanner state enumeration.
REQ-030 Combinational (row index, column index) to code mapping SHALL live in sub-module keypad_decode.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-031 Hold key r1/c2 ('6') low 40 cycles -> exactly one trig, value=4'h6, clr_entry and clr_all stay 1.
REQ-032 Press r3/c3 ('D') -> trig with value=4'hD and clr_all low in the same cycle; press r2/c3 ('C') -> clr_entry low with trig.
REQ-033 Bounce r0/c0 low 5 cycles, high 2, low 5 -> no trig; then hold low 12 -> one trig, value=4'h1.
REQ-034 Rows r0 and r1 low together on column 1 -> no trig and scanning continues; col sequence 1110, 1101, 1011, 0111 repeats.
REQ-035 Hold '5', then press '9' during HOLD, release both -> a single trig (value=4'h5); a later '9' press -> trig, value=4'h9.
REQ-036 Assert reset at DEBOUNCE count 6 -> outputs at reset values, no trig; release reset and keep the key held -> trig after a full 8-sample debounce.
